// File: rtl/score_display.sv
// score_display: left/right scores rendered as 7-segment digits on the pixel stream.
// SCORE_BLINK_EN: winner digit blinks 16 frames on / 16 off after game over.
module score_display #(
  parameter int LX        = 160,
  parameter int RX        = 460,
  parameter int Y0        = 32,
  parameter int DIGIT_W   = 20,
  parameter int DIGIT_H   = 36,
  parameter int SEG_T     = 4,
  parameter int WIN_SCORE = 9
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  logic       i_de,
  input  logic       i_point_l,
  input  logic       i_point_r,
  input  logic       i_new_game,
  input  logic       i_frame_tick,
  output logic [3:0] o_rom_addr,
  input  logic [6:0] i_rom_data,
  output logic       o_pixel_on,
  output logic [3:0] o_score_l,
  output logic [3:0] o_score_r,
  output logic       o_game_over
);

  localparam logic [9:0] L0   = 10'(LX);
  localparam logic [9:0] L1   = 10'(LX + DIGIT_W);
  localparam logic [9:0] R0   = 10'(RX);
  localparam logic [9:0] R1   = 10'(RX + DIGIT_W);
  localparam logic [9:0] T0   = 10'(Y0);
  localparam logic [9:0] T1   = 10'(Y0 + DIGIT_H);
  localparam logic [9:0] ST   = 10'(SEG_T);
  localparam logic [9:0] WT   = 10'(DIGIT_W - SEG_T);
  localparam logic [9:0] HH   = 10'(DIGIT_H / 2);
  localparam logic [9:0] MID0 = 10'(DIGIT_H / 2 - SEG_T / 2);
  localparam logic [9:0] MID1 = 10'(DIGIT_H / 2 + SEG_T / 2);
  localparam logic [9:0] HT   = 10'(DIGIT_H - SEG_T);
  localparam logic [3:0] WIN  = 4'(WIN_SCORE);

  logic [3:0] score_l_q, score_l_d;
  logic [3:0] score_r_q, score_r_d;
  logic       game_over_q, game_over_d;
  logic [9:0] dx_q, dx_d;
  logic [9:0] dy_q, dy_d;
  logic       in_cell_q, in_cell_d;
  logic       sel_r_q, sel_r_d;
  logic       pixel_on_q, pixel_on_d;
  logic       in_l, in_r, in_y;
  logic       upper, lower;
  logic [6:0] seg;
  logic       blank;

  always_comb begin
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    game_over_d = game_over_q
                | (score_l_q == WIN)
                | (score_r_q == WIN);
    if (i_new_game) begin
      score_l_d   = '0;
      score_r_d   = '0;
      game_over_d = 1'b0;
    end else if (!game_over_q) begin
      if (i_point_l && score_l_q != WIN)
        score_l_d = score_l_q + 4'd1;
      if (i_point_r && score_r_q != WIN)
        score_r_d = score_r_q + 4'd1;
    end
  end

  always_comb begin
    in_y       = (i_y >= T0) && (i_y < T1);
    in_l       = in_y && (i_x >= L0) && (i_x < L1);
    in_r       = in_y && (i_x >= R0) && (i_x < R1);
    o_rom_addr = in_r ? score_r_q : score_l_q;
    dx_d       = in_r ? (i_x - R0) : (i_x - L0);
    dy_d       = i_y - T0;
    in_cell_d  = (in_l | in_r) & i_de;
    sel_r_d    = in_r;
  end

  always_comb begin
    upper  = dy_q < HH;
    lower  = !upper;
    seg[0] = dy_q < ST;
    seg[1] = (dx_q < ST) && upper;
    seg[2] = (dx_q >= WT) && upper;
    seg[3] = (dy_q >= MID0) && (dy_q < MID1);
    seg[4] = (dx_q < ST) && lower;
    seg[5] = (dx_q >= WT) && lower;
    seg[6] = dy_q >= HT;
    pixel_on_d = in_cell_q & ~blank
               & (|(i_rom_data & seg));
  end

`ifdef SCORE_BLINK_EN
  logic [4:0] blink_q, blink_d;
  logic       winner;

  always_comb begin
    blink_d = blink_q;
    if (i_new_game || !game_over_q)
      blink_d = '0;
    else if (i_frame_tick)
      blink_d = blink_q + 5'd1;
    winner = sel_r_q ? (score_r_q == WIN)
                     : (score_l_q == WIN);
    blank  = blink_q[4] & winner;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) blink_q <= '0;
    else          blink_q <= blink_d;
  end
`else
  logic unused_tick;
  assign unused_tick = i_frame_tick;
  assign blank       = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      score_l_q   <= '0;
      score_r_q   <= '0;
      game_over_q <= 1'b0;
      dx_q        <= '0;
      dy_q        <= '0;
      in_cell_q   <= 1'b0;
      sel_r_q     <= 1'b0;
      pixel_on_q  <= 1'b0;
    end else begin
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      game_over_q <= game_over_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      in_cell_q   <= in_cell_d;
      sel_r_q     <= sel_r_d;
      pixel_on_q  <= pixel_on_d;
    end
  end

  assign o_pixel_on  = pixel_on_q;
  assign o_score_l   = score_l_q;
  assign o_score_r   = score_r_q;
  assign o_game_over = game_over_q;

endmodule

// File: tb/tb_score_display.sv
// tb_score_display: reference model plus directed pixel/score vectors.
// Build with +define+SCORE_BLINK_EN to exercise the blink feature.
module tb_score_display;

  localparam int LX = 160, RX = 460, Y0 = 32;
  localparam int W = 20, H = 36, T = 4, WIN = 9;
`ifdef SCORE_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] x = '0, y = '0;
  logic       de = 1'b0, pl = 1'b0, pr = 1'b0;
  logic       ng = 1'b0, ft = 1'b0;
  logic [3:0] rom_addr;
  logic [6:0] rom_data;
  logic       pixel_on;
  logic [3:0] sl, sr;
  logic       go;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  score_display dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_x(x), .i_y(y), .i_de(de),
    .i_point_l(pl), .i_point_r(pr),
    .i_new_game(ng), .i_frame_tick(ft),
    .o_rom_addr(rom_addr), .i_rom_data(rom_data),
    .o_pixel_on(pixel_on),
    .o_score_l(sl), .o_score_r(sr),
    .o_game_over(go)
  );

  // Digit font: bit0 top, 1 UL, 2 UR, 3 mid, 4 LL, 5 LR, 6 bottom
  function automatic logic [6:0] font_of(int d);
    case (d)
      0: return 7'b1110111;
      1: return 7'b0100100;
      2: return 7'b1011101;
      3: return 7'b1101101;
      4: return 7'b0101110;
      5: return 7'b1101011;
      6: return 7'b1111011;
      7: return 7'b0100101;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) rom_data <= '0;
    else        rom_data <= font_of(int'(rom_addr));

  // Segment k as a rectangle [x0,x1) x [y0,y1) inside the cell
  function automatic bit in_seg(int k, int dx, int dy);
    int x0, x1, y0, y1;
    x0 = 0; x1 = W; y0 = 0; y1 = H;
    case (k)
      0: y1 = T;
      1: begin x1 = T; y1 = H / 2; end
      2: begin x0 = W - T; y1 = H / 2; end
      3: begin y0 = H / 2 - T / 2; y1 = H / 2 + T / 2; end
      4: begin x1 = T; y0 = H / 2; end
      5: begin x0 = W - T; y0 = H / 2; end
      default: y0 = H - T;
    endcase
    return dx >= x0 && dx < x1 && dy >= y0 && dy < y1;
  endfunction

  function automatic bit in_right(int px, int py);
    return px >= RX && px < RX + W && py >= Y0 && py < Y0 + H;
  endfunction

  function automatic bit lit(int px, int py, bit pde, int s_l, int s_r);
    int ox, digit;
    logic [6:0] f;
    if (!pde || py < Y0 || py >= Y0 + H) return 1'b0;
    if (px >= LX && px < LX + W) begin ox = LX; digit = s_l; end
    else if (px >= RX && px < RX + W) begin ox = RX; digit = s_r; end
    else return 1'b0;
    f = font_of(digit);
    for (int k = 0; k < 7; k++)
      if (f[k] && in_seg(k, px - ox, py - Y0)) return 1'b1;
    return 1'b0;
  endfunction

  int m_sl, m_sr, m_cnt, m_side;
  bit m_go, m_lit, m_out;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sl <= 0; m_sr <= 0; m_go <= 1'b0; m_cnt <= 0;
      m_lit <= 1'b0; m_side <= 0; m_out <= 1'b0;
    end else begin
      automatic int nl = m_sl;
      automatic int nr = m_sr;
      automatic bit off;
      off = BLINK && m_cnt >= 16
            && ((m_side == 1) ? m_sr : m_sl) == WIN;
      m_out  <= m_lit && !off;
      m_lit  <= lit(int'(x), int'(y), de, m_sl, m_sr);
      m_side <= in_right(int'(x), int'(y)) ? 1 : 0;
      if (ng || !m_go) m_cnt <= 0;
      else if (ft)     m_cnt <= (m_cnt + 1) % 32;
      if (ng) begin
        nl = 0; nr = 0;
        m_go <= 1'b0;
      end else begin
        if (m_sl == WIN || m_sr == WIN) m_go <= 1'b1;
        if (!m_go) begin
          if (pl && nl < WIN) nl++;
          if (pr && nr < WIN) nr++;
        end
      end
      m_sl <= nl;
      m_sr <= nr;
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_score_l", 32'(sl), 32'(m_sl));
      chk("m_score_r", 32'(sr), 32'(m_sr));
      chk("m_game_over", 32'(go), 32'(m_go));
      chk("m_pixel", 32'(pixel_on), 32'(m_out));
      chk("m_addr", 32'(rom_addr),
          32'(in_right(int'(x), int'(y)) ? m_sr : m_sl));
    end
  end

  task automatic pulse(bit l, bit r, bit n, bit f);
    @(posedge clk); #1;
    pl = l; pr = r; ng = n; ft = f;
    @(posedge clk); #1;
    pl = 1'b0; pr = 1'b0; ng = 1'b0; ft = 1'b0;
  endtask

  task automatic pix(string nm, int px, int py, bit pde,
                     int eaddr, bit epix);
    @(posedge clk); #1;
    x = 10'(px); y = 10'(py); de = pde;
    @(negedge clk);
    chk({nm, "_addr"}, 32'(rom_addr), 32'(eaddr));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk(nm, 32'(pixel_on), 32'(epix));
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2;
    chk("rst_score_l", 32'(sl), 0);
    chk("rst_score_r", 32'(sr), 0);
    chk("rst_game_over", 32'(go), 0);
    chk("rst_pixel", 32'(pixel_on), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    pix("top0", LX + 8, Y0 + 1, 1'b1, 0, 1'b1);
    pix("mid0", LX + 8, Y0 + 18, 1'b1, 0, 1'b0);
    pix("bot0", LX + 10, Y0 + H - 1, 1'b1, 0, 1'b1);
    pix("edge0", LX + W - 1, Y0 + 1, 1'b1, 0, 1'b1);
    pix("out0", LX + W, Y0 + 1, 1'b1, 0, 1'b0);

    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk("one_l", 32'(sl), 1);
    pix("ur1", LX + 18, Y0 + 5, 1'b1, 1, 1'b1);
    pix("ul1", LX + 1, Y0 + 5, 1'b1, 1, 1'b0);

    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) pulse(1'b1, 1'b1, 1'b0, 1'b0);
    chk("both3_l", 32'(sl), 3);
    chk("both3_r", 32'(sr), 3);
    chk("both3_go", 32'(go), 0);
    pix("mid3r", RX + 10, Y0 + 18, 1'b1, 3, 1'b1);

    repeat (6) pulse(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("win_l", 32'(sl), 9);
    chk("go_pending", 32'(go), 0);
    @(negedge clk);
    chk("go_set", 32'(go), 1);
    repeat (2) pulse(1'b0, 1'b1, 1'b0, 1'b0);
    chk("frozen_r", 32'(sr), 3);
    chk("frozen_l", 32'(sl), 9);

    pix("win_on", LX + 8, Y0 + 1, 1'b1, 9, 1'b1);
    repeat (16) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pix("win_blink", LX + 8, Y0 + 1, 1'b1, 9, !BLINK);
    pix("lose_steady", RX + 8, Y0 + 1, 1'b1, 3, 1'b1);
    repeat (16) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pix("win_back", LX + 8, Y0 + 1, 1'b1, 9, 1'b1);

    pulse(1'b1, 1'b0, 1'b1, 1'b0);
    chk("ng_l", 32'(sl), 0);
    chk("ng_r", 32'(sr), 0);
    chk("ng_go", 32'(go), 0);
    pix("de_off", LX + 8, Y0 + 1, 1'b0, 0, 1'b0);
    pix("de_on", LX + 8, Y0 + 1, 1'b1, 0, 1'b1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
